// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Request-side driver for the datapath ALU. Accepts one operation at a time,
// drives the ALU operand/control inputs, captures the ALU's combinational
// result and returns it on a response channel. MUL is a WIDTH-step shift-add
// built from repeated ALU ADDs, so the ALU itself needs no multiplier.
//
// Ports:
//   CLK, Reset_L                 clock, asynchronous active-low reset
//   ReqValid/ReqReady            request handshake
//   ReqOp, ReqA, ReqB            opcode (0 AND,1 OR,2 ADD,3 SUB,4 PASSB,5 MUL,
//                                6 CMP,7 illegal) and operands
//   RspValid/RspReady            response handshake
//   RspData, RspZero, RspErr     result, zero flag, illegal-opcode flag
//   AluBusA, AluBusB, AluCtrl    drive the ALU inputs
//   AluBusW, AluZero             ALU combinational result and zero flag
//   DbgState                     current FSM state (IDLE=0 EXEC=1 MUL=2 RESP=3)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. ReqReady is high only in IDLE; RspValid is high only in RESP,
// and the response fields are held constant until RspReady accepts them.
// Neither valid depends combinationally on the opposite ready.

module alu_op_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [2:0]       ReqOp,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspData,
    output logic             RspZero,
    output logic             RspErr,
    output logic [WIDTH-1:0] AluBusA,
    output logic [WIDTH-1:0] AluBusB,
    output logic [3:0]       AluCtrl,
    input  logic [WIDTH-1:0] AluBusW,
    input  logic             AluZero,
    output logic [1:0]       DbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_MUL   = 3'd5;
    localparam logic [2:0] OP_CMP   = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    localparam logic [3:0] CTRL_AND   = 4'b0000;
    localparam logic [3:0] CTRL_OR    = 4'b0001;
    localparam logic [3:0] CTRL_ADD   = 4'b0010;
    localparam logic [3:0] CTRL_SUB   = 4'b0110;
    localparam logic [3:0] CTRL_PASSB = 4'b0111;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [2:0]       op;
    logic [WIDTH-1:0] acc;
    // mcand/mplier double as the latched A/B operands for the simple ops,
    // which only need them unshifted for their single EXEC cycle.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // Opcode to ALU control; PASSB is the fallback so AluCtrl can never carry
    // an encoding the ALU does not implement. CMP is a SUB and reads Zero.
    function automatic logic [3:0] map_ctrl(input logic [2:0] o);
        logic [3:0] c;
        case (o)
            OP_AND:         c = CTRL_AND;
            OP_OR:          c = CTRL_OR;
            OP_ADD:         c = CTRL_ADD;
            OP_SUB, OP_CMP: c = CTRL_SUB;
            default:        c = CTRL_PASSB;
        endcase
        return c;
    endfunction

    // ALU drive is a pure decode of registered state, so it is stable for the
    // whole cycle and the ALU result settles before the capturing edge.
    always_comb begin
        AluBusA = '0;
        AluBusB = '0;
        AluCtrl = CTRL_PASSB;
        case (state)
            EXEC: begin
                AluBusA = mcand;
                AluBusB = mplier;
                AluCtrl = map_ctrl(op);
            end
            MUL: begin
                AluBusA = acc;
                AluBusB = mplier[0] ? mcand : '0;
                AluCtrl = CTRL_ADD;
            end
            default: ;
        endcase
    end

    assign ReqReady = (state == IDLE);
    assign RspValid = (state == RESP);
    assign DbgState = state;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state   <= IDLE;
            op      <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            RspData <= '0;
            RspZero <= 1'b0;
            RspErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        op     <= ReqOp;
                        mcand  <= ReqA;
                        mplier <= ReqB;
                        acc    <= '0;
                        cnt    <= '0;
                        if (ReqOp == OP_ILL) begin
                            RspData <= '0;
                            RspZero <= 1'b0;
                            RspErr  <= 1'b1;
                            state   <= RESP;
                        end else if (ReqOp == OP_MUL) begin
                            state <= MUL;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    RspData <= (op == OP_CMP) ? {{(WIDTH-1){1'b0}}, AluZero} : AluBusW;
                    RspZero <= AluZero;
                    RspErr  <= 1'b0;
                    state   <= RESP;
                end
                MUL: begin
                    acc    <= AluBusW;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        // The final ADD's result is the truncated product.
                        RspData <= AluBusW;
                        RspZero <= AluZero;
                        RspErr  <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (RspReady) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Request-side driver for the datapath ALU. It accepts operation requests over a valid/ready handshake and drives the ALU operand and control inputs (BusA, BusB, ALUCtrl). It captures the ALU's combinational BusW/Zero and returns them over a valid/ready response channel. It also builds a 64-step shift-add multiply from repeated ALU ADDs, so the ALU itself is unchanged.

## Interface
- WIDTH, 64, operand/result width; the ALU port widths match it
- CNT_W, 7, iteration counter width; must hold WIDTH
- CLK  in  1  clock; all state updates on the rising edge
- Reset_L  in  1  reset, asynchronous and active-low
- ReqValid  in  1  request valid
- ReqReady  out  1  request ready; high only in IDLE
- ReqOp  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 PASSB, 5 MUL, 6 CMP, 7 illegal
- ReqA  in  WIDTH  operand A
- ReqB  in  WIDTH  operand B
- RspValid  out  1  response valid
- RspReady  in  1  response accepted
- RspData  out  WIDTH  result
- RspZero  out  1  zero flag
- RspErr  out  1  illegal opcode flag
- AluBusA  out  WIDTH  drives ALU BusA
- AluBusB  out  WIDTH  drives ALU BusB
- AluCtrl  out  4  drives ALU ALUCtrl
- AluBusW  in  WIDTH  ALU result, combinational
- AluZero  in  1  ALU Zero, combinational

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111. CMP issues SUB.
- The ALU has no other encodings. AluCtrl only ever carries these five values.
- States: IDLE, EXEC, MUL, RESP.
- **IDLE**
  - ReqReady=1.
  - A handshake (ReqValid & ReqReady) latches ReqA, ReqB and ReqOp.
  - Ops 0-4 and 6 go to EXEC.
  - Op 5 goes to MUL, with acc=0, mcand=A, mplier=B, cnt=0.
  - Op 7 goes to RESP with RspData=0, RspZero=0, RspErr=1. The ALU is not used.
- **EXEC**
  - Drives AluBusA=A, AluBusB=B and the mapped AluCtrl for one cycle.
  - At the edge, registers the response fields and goes to RESP:
    - ops 0-4: RspData=AluBusW, RspZero=AluZero.
    - CMP: RspData = zero-extended AluZero (1 iff A==B), RspZero=AluZero.
    - RspErr=0.
- **MUL**, one iteration per cycle:
  - Drives AluCtrl=ADD, AluBusA=acc, AluBusB = mplier[0] ? mcand : 0.
  - At the edge: acc<=AluBusW, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - After the WIDTH-th iteration (cnt==WIDTH-1 at the edge), goes to RESP.
  - RspData = low WIDTH bits of A*B, with overflow discarded by the ALU's modular add.
  - RspZero = AluZero of the final ADD. RspErr=0.
- **RESP**
  - RspValid=1. Response fields stay stable while RspValid is high.
  - When RspReady=1, goes to IDLE.
  - The same edge does not accept a new request, because ReqReady=0 in RESP.
- ALU port defaults in IDLE and RESP: AluBusA=0, AluBusB=0, AluCtrl=PassB.
- Arithmetic wraps modulo 2^WIDTH. There is no overflow or carry output.

## Timing
- Reset values:
  - state IDLE, ReqReady=1, RspValid=0.
  - RspData=0, RspZero=0, RspErr=0.
  - AluBusA=0, AluBusB=0, AluCtrl=0111.
  - acc, mcand, mplier and cnt are 0.
- Reset_L low at any time, mid-MUL included, aborts the in-flight op at once. No response is produced for it.
- Simple op latency: handshake at edge k, EXEC during cycle k+1, RspValid high after edge k+2.
- MUL latency: handshake at edge k, RspValid high after edge k+WIDTH+1 (65 cycles at WIDTH=64).
- Illegal op latency: RspValid high after edge k+1.
- Peak throughput with RspReady tied high: one simple op per 3 cycles, one MUL per WIDTH+2 cycles.
- ReqA, ReqB and ReqOp are sampled only at the handshake edge. Later changes have no effect.
- A held RspReady=0 stalls the block indefinitely in RESP. Outputs hold and no request is accepted.

## Test plan
- **Reset:** with Reset_L=0, check ReqReady=1, RspValid=0, AluCtrl=0111 and every other output 0.
- **Simple ops:** ADD with A=5, B=7 gives RspData=12, RspZero=0, RspValid 2 cycles after the handshake.
  - SUB with A=9, B=9 gives RspData=0, RspZero=1.
  - AND 0xF0F0 with 0x0FF0 gives 0x00F0.
  - OR 0xF000 with 0x000F gives 0xF00F.
  - PASSB with B=0xDEAD gives 0xDEAD.
- **Compare, illegal op, backpressure:**
  - CMP with A=B=0x1234 gives RspData=1, RspZero=1. CMP with A=1, B=2 gives RspData=0, RspZero=0.
  - Op 7 gives RspErr=1, RspData=0 one cycle after the handshake, with AluCtrl still 0111.
  - Hold RspReady=0 for 10 cycles: RspValid and RspData stay stable, ReqReady=0, and ReqValid pulses in this window are not taken.
- **Multiply:**
  - MUL 3 x 7 gives 21 exactly 65 cycles after the handshake. AluCtrl=0010 during all 64 MUL cycles.
  - MUL 0xFFFFFFFFFFFFFFFF x 2 gives 0xFFFFFFFFFFFFFFFE.
  - MUL 0 x 123 gives 0 with RspZero=1.
- **Reset mid-op:** assert Reset_L=0 at MUL iteration 30. All outputs return to reset values and no response appears. A following ADD 1+1 returns 2 with normal latency.
